pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the in-order core; successor to the fixed 6-bit stall/flush controller.
- Resolves per-stage stall requests into a stall mask. Generates per-stage flush vectors for redirects.
- Holds a redirect that arrives while the PC is frozen, and sequences trap entry through a drain FSM.
- Provides a saturating stall-cycle counter and a stall watchdog.
- Stage index 0 = PC, 1 = IF_ID, 2 = ID_EX, 3 = EX_MEM, 4 = MEM_WB; higher indices are spare.

Parameters:
- NUM_STAGES, 6, width of the stall and flush vectors; index 0 is the PC.
- ADDR_WIDTH, 32, PC width.
- SIDX_W, 3, width of a stage index; must satisfy 2^SIDX_W >= NUM_STAGES.
- DRAIN_CYCLES, 3, cycles the PC is held in trap DRAIN; legal range 1..15.
- STALL_TIMEOUT, 1024, consecutive PC-stall cycles that trip the watchdog.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- stall_req_i  in  NUM_STAGES  bit k set = stage k requests a hold
- redir_valid_i  in  1  control-flow redirect request
- redir_stage_i  in  SIDX_W  stage raising the redirect (1..NUM_STAGES-1)
- redir_addr_i  in  ADDR_WIDTH  redirect target
- trap_req_i  in  1  trap/interrupt entry request (level)
- trap_vec_i  in  ADDR_WIDTH  trap handler address
- stall_o  out  NUM_STAGES  per-stage hold
- flush_o  out  NUM_STAGES  per-stage bubble insert
- new_pc_valid_o  out  1  PC load strobe
- new_pc_o  out  ADDR_WIDTH  PC load value
- trap_ack_o  out  1  one-cycle pulse when the trap vector is issued
- stall_cnt_o  out  32  saturating count of cycles with stall_o[0]=1
- stall_timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - FSM goes to IDLE; pending redirect is cleared; stall_cnt_o = 0; stall_timeout_o = 0; watchdog counter = 0.
  - While rst_i=1, all combinational outputs (stall_o, flush_o, new_pc_valid_o, new_pc_o, trap_ack_o) are forced to 0.
  - Reset mid-DRAIN or with a redirect pending discards the trap/redirect; no PC load follows.
- Stall mask (combinational, IDLE): let k = highest set index of stall_req_i. Then stall_o[i] = 1 for all i <= k, else 0. No request gives stall_o = 0.
- Redirect, IDLE, redir_valid_i=1 with stage s:
  - flush_o[i] = 1 for 1 <= i <= s, same cycle. flush_o[0] is always 0.
  - Stall and flush both asserted on a stage: flush wins; the stage loads a bubble.
  - If stall_o[0]=0: new_pc_valid_o=1 and new_pc_o=redir_addr_i in the same cycle (0 latency).
  - Else: target and s are latched into a pending register. new_pc_valid_o=1 with the latched target is emitted in the first cycle stall_o[0]=0.
  - A new redirect while pending replaces the pending entry if its s >= pending stage; otherwise it is ignored.
  - A new redirect in the same cycle the pending entry drains takes priority (0 latency); the pending entry is dropped.
  - redir_stage_i = 0 or >= NUM_STAGES: request ignored.
- Trap FSM: IDLE -> DRAIN -> ISSUE -> IDLE.
  - IDLE -> DRAIN: when trap_req_i=1 at a clk_i edge. Trap has priority over any same-cycle redirect, which is dropped; the pending redirect is cleared.
  - DRAIN (DRAIN_CYCLES cycles):
    - stall_o[0] = 1; flush_o[1] = 1; other stall bits follow the stall mask; redir inputs are ignored.
    - The drain counter advances only in cycles where stall_req_i has no bit above index 0.
  - ISSUE (1 cycle): new_pc_valid_o=1, new_pc_o=trap_vec_i, trap_ack_o=1, flush_o[NUM_STAGES-1:1] all 1, stall_o = 0. Then IDLE.
  - trap_req_i held high re-enters DRAIN from IDLE on the next edge.
- stall_cnt_o: +1 on each edge where stall_o[0]=1; saturates at 0xFFFFFFFF.
- Watchdog: counts consecutive cycles with stall_o[0]=1 and clears when stall_o[0]=0. Reaching STALL_TIMEOUT sets stall_timeout_o, which holds until reset.
- Outside ISSUE, new_pc_o = 0 whenever new_pc_valid_o = 0.

Test Plan:
- stall_req_i=6'b001000 -> stall_o=6'b001111, flush_o=0; stall_req_i=6'b000100 -> stall_o=6'b000111.
- redir_valid_i=1, s=2, addr=0x100, no stall -> flush_o=6'b000110; new_pc_valid_o=1, new_pc_o=0x100 in the same cycle.
- stall_req_i=6'b000100 held 3 cycles with redirect s=3, addr=0x200 in cycle 1 -> no PC load in cycles 1-3; new_pc_valid_o=1, new_pc_o=0x200 in cycle 4. A second redirect s=1 in cycle 2 is ignored.
- trap_req_i pulse with trap_vec_i=0x80, DRAIN_CYCLES=3, no stalls:
  - 3 cycles of stall_o[0]=1, flush_o[1]=1;
  - then 1 cycle with trap_ack_o=1, new_pc_o=0x80, flush_o=6'b111110;
  - back in IDLE on the next cycle. A trap and a redirect in the same cycle -> only the trap vector is issued.
- STALL_TIMEOUT=8, stall_req_i[0] held 8 cycles -> stall_timeout_o=1 and stays 1 after the stall is released; stall_cnt_o=8.
- rst_i=1 asserted mid-DRAIN -> next cycle all outputs 0, FSM in IDLE, no trap_ack_o pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves stall requests into a stall mask, issues redirect
// flushes and PC loads (holding a redirect while the PC is frozen), sequences trap entry
// through a drain FSM, and tracks stall statistics with a saturating counter and a watchdog.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES    = 6,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned SIDX_W        = 3,
  parameter int unsigned DRAIN_CYCLES  = 3,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_STAGES-1:0] stall_req_i,
  input  logic                  redir_valid_i,
  input  logic [SIDX_W-1:0]     redir_stage_i,
  input  logic [ADDR_WIDTH-1:0] redir_addr_i,
  input  logic                  trap_req_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  new_pc_valid_o,
  output logic [ADDR_WIDTH-1:0] new_pc_o,
  output logic                  trap_ack_o,
  output logic [31:0]           stall_cnt_o,
  output logic                  stall_timeout_o
);

  localparam int unsigned     WdW        = $clog2(STALL_TIMEOUT + 1);
  localparam logic [SIDX_W:0] NumStagesW = (SIDX_W + 1)'(NUM_STAGES);
  localparam logic [3:0]      DrainLast  = 4'(DRAIN_CYCLES - 1);
  localparam logic [WdW-1:0]  WdLast     = WdW'(STALL_TIMEOUT - 1);
  localparam logic [WdW-1:0]  WdMax      = WdW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDrain, StIssue} state_e;

  state_e                state_q, state_d;
  logic [3:0]            drain_cnt_q, drain_cnt_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [SIDX_W-1:0]     pend_stage_q, pend_stage_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
  logic [WdW-1:0]        wd_cnt_q, wd_cnt_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_STAGES-1:0] stall_mask;
  logic [NUM_STAGES-1:0] redir_flush;
  logic                  redir_ok;
  logic                  drain_adv;

  // Stall mask: every stage at or below the highest requester holds.
  always_comb begin
    stall_mask = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      stall_mask[i] = |(stall_req_i >> i);
    end
  end

  // Redirect flush vector: bubble stages 1..s; the PC slot is never flushed.
  always_comb begin
    redir_flush = '0;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      redir_flush[i] = (SIDX_W'(i) <= redir_stage_i);
    end
  end

  assign redir_ok  = redir_valid_i && (redir_stage_i != '0) &&
                     ({1'b0, redir_stage_i} < NumStagesW);
  // Drain only makes progress while nothing past the PC is holding.
  assign drain_adv = ~|stall_req_i[NUM_STAGES-1:1];

  // Outputs and FSM / pending-redirect next state.
  always_comb begin
    stall_o        = '0;
    flush_o        = '0;
    new_pc_valid_o = 1'b0;
    new_pc_o       = '0;
    trap_ack_o     = 1'b0;
    state_d        = state_q;
    drain_cnt_d    = drain_cnt_q;
    pend_valid_d   = pend_valid_q;
    pend_stage_d   = pend_stage_q;
    pend_addr_d    = pend_addr_q;

    unique case (state_q)
      StIdle: begin
        stall_o = stall_mask;
        if (trap_req_i) begin
          // Trap wins: same-cycle and pending redirects are discarded.
          state_d      = StDrain;
          drain_cnt_d  = '0;
          pend_valid_d = 1'b0;
        end else begin
          if (redir_ok) begin
            flush_o = redir_flush;
          end
          if (!stall_mask[0]) begin
            if (redir_ok) begin
              new_pc_valid_o = 1'b1;
              new_pc_o       = redir_addr_i;
              pend_valid_d   = 1'b0;
            end else if (pend_valid_q) begin
              new_pc_valid_o = 1'b1;
              new_pc_o       = pend_addr_q;
              pend_valid_d   = 1'b0;
            end
          end else if (redir_ok && (!pend_valid_q || (redir_stage_i >= pend_stage_q))) begin
            // Older (deeper or equal) redirect replaces the held one.
            pend_valid_d = 1'b1;
            pend_stage_d = redir_stage_i;
            pend_addr_d  = redir_addr_i;
          end
        end
      end
      StDrain: begin
        stall_o    = stall_mask;
        stall_o[0] = 1'b1;
        flush_o    = NUM_STAGES'(2);
        if (drain_adv) begin
          if (drain_cnt_q == DrainLast) begin
            state_d = StIssue;
          end else begin
            drain_cnt_d = drain_cnt_q + 4'd1;
          end
        end
      end
      StIssue: begin
        new_pc_valid_o = 1'b1;
        new_pc_o       = trap_vec_i;
        trap_ack_o     = 1'b1;
        flush_o        = ~NUM_STAGES'(1);
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rst_i) begin
      stall_o        = '0;
      flush_o        = '0;
      new_pc_valid_o = 1'b0;
      new_pc_o       = '0;
      trap_ack_o     = 1'b0;
    end
  end

  // Saturating stall counter and consecutive-stall watchdog.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    timeout_d   = timeout_q;
    if (stall_o[0]) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (wd_cnt_q != WdMax) begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
      if (wd_cnt_q >= WdLast) begin
        timeout_d = 1'b1;
      end
    end else begin
      wd_cnt_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      drain_cnt_q  <= '0;
      pend_valid_q <= 1'b0;
      pend_stage_q <= '0;
      pend_addr_q  <= '0;
      stall_cnt_q  <= '0;
      wd_cnt_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_cnt_q  <= drain_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_stage_q <= pend_stage_d;
      pend_addr_q  <= pend_addr_d;
      stall_cnt_q  <= stall_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  assign stall_cnt_o     = stall_cnt_q;
  assign stall_timeout_o = timeout_q;

endmodule
